matmul_engine: RTL and testbench
================================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 The block SHALL provide parameter N, default 4, meaning matrix dimension (square N x N, N >= 2, power of two).
REQ-002 The block SHALL provide parameter DW, default 8, meaning operand element width in bits.
REQ-003 The block SHALL provide parameter ACC_W, default 2*DW+$clog2(N), meaning result element width in bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand pair on a_flat/b_flat is valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a_flat  input  N*N*DW  matrix A, element (i,j) at bits [(i*N+j)*DW +: DW].
REQ-009 b_flat  input  N*N*DW  matrix B, same packing as a_flat.
REQ-010 out_valid  output  1  c_flat holds a completed result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 c_flat  output  N*N*ACC_W  result C = A x B, element (i,j) at bits [(i*N+j)*ACC_W +: ACC_W].
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, COMPUTE and DONE.
REQ-015 in_ready SHALL be high only in IDLE; an input handshake is in_valid && in_ready.
REQ-016 On an input handshake, A and B SHALL be registered internally, all N*N accumulators cleared, k counter set to 0, and the state SHALL move to COMPUTE.
REQ-017 In COMPUTE, each cycle every accumulator (i,j) SHALL add A[i][k]*B[k][j], and k SHALL increment; after the cycle with k = N-1, the state SHALL move to DONE.
REQ-018 Latency: handshake at cycle t SHALL give out_valid high at cycle t+N+1.
REQ-019 In DONE, out_valid SHALL be high and c_flat SHALL hold stable until out_ready is sampled high, after which the state SHALL return to IDLE with out_valid low the next cycle.
REQ-020 in_valid and input data changes outside IDLE SHALL be ignored; registered operands SHALL be unaffected.
REQ-021 Products SHALL be 2*DW bits and sums ACC_W bits; no overflow or saturation is possible at the defaults, and for any ACC_W smaller than the default, results SHALL wrap modulo 2^ACC_W.
REQ-022 c_flat SHALL be driven from registers only, with no combinational path from any input.
REQ-023 out_ready high while out_valid is low SHALL have no effect.

Reset
REQ-024 rst high SHALL force state IDLE, in_ready=1 (from the following cycle), out_valid=0, busy=0, c_flat=0 and k=0, regardless of state.
REQ-025 rst asserted during COMPUTE or DONE SHALL abort the operation and discard the partial or held result without emitting out_valid.

Configuration
REQ-026 With macro MATMUL_SIGNED_EN defined, operands SHALL be two's-complement signed and products and accumulation sign-extended to ACC_W.
REQ-027 Without MATMUL_SIGNED_EN, operands SHALL be unsigned and zero-extended, and the block SHALL be bit-compatible with a 4x4 8-bit unsigned combinational multiply whose results are widened to ACC_W.

Structure
REQ-028 A shared package matmul_pkg SHALL hold the FSM state typedef, default N/DW constants and an ACC_W helper function.
REQ-029 The per-element multiply-accumulate SHALL be a sub-module matmul_mac (one DW x DW product into an ACC_W accumulator with clear and enable), instantiated N*N times.

Verification
REQ-030 A = identity, B elements = 1..16 row-major, N=4 -> c_flat equals B widened to 18 bits, out_valid at handshake+5.
REQ-031 A and B all 0xFF, unsigned -> every C element = 260100 (0x3F804), no wrap.
REQ-032 With MATMUL_SIGNED_EN, A and B all 0x80 -> every C element = +65536. With a[0][0]=0xFF (-1), B = identity, and all other A elements 0 -> C[0][0] = 0x3FFFF.
REQ-033 out_ready held low for 10 cycles after out_valid -> c_flat stable and in_ready low throughout. A second in_valid during this window is ignored.
REQ-034 rst pulsed at COMPUTE cycle k=2 -> out_valid never asserts, and the next operation, started with new operands, produces correct results.
REQ-035 Back-to-back operations with out_ready tied high -> an accepted handshake every N+2 cycles, each result matching a reference model.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: FSM state encoding,
// default geometry and the result-width helper.
// Optional feature macro: MATMUL_SIGNED_EN (two's-complement operands).
package matmul_pkg;

    // Default matrix dimension and operand width
    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;

    // Engine control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Width needed to hold a full N-term dot product of DW-bit operands
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// One multiply-accumulate cell: a DW x DW product summed into an ACC_W
// accumulator with synchronous clear and enable.
// Optional feature macro: MATMUL_SIGNED_EN (signed operands, sign-extended sums).
module matmul_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    output logic [ACC_W-1:0] acc
);

    // Product is extended to the wider of product/accumulator width, then
    // truncated to ACC_W so narrow accumulators wrap modulo 2^ACC_W.
    localparam int PW = (ACC_W > 2 * DW) ? ACC_W : 2 * DW;

    logic [2*DW-1:0]  prod;
    logic [PW-1:0]    prod_ext;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;

    // Form the product and the next accumulator value; clear wins over enable
    always_comb begin
        prod     = '0;
        prod_ext = '0;
        acc_d    = acc_q;
`ifdef MATMUL_SIGNED_EN
        prod     = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
        prod_ext = PW'($signed(prod));
`else
        prod     = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
        prod_ext = PW'(prod);
`endif
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_ext[ACC_W-1:0];
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Iterative N x N matrix multiplier: operands are captured on a valid/ready
// handshake, one inner-product term per cycle is added into N*N MAC cells,
// and the result is held until the consumer accepts it.
// Optional feature macro: MATMUL_SIGNED_EN (two's-complement operands).
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = acc_width(N, DW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*DW-1:0]      a_flat,
    input  logic [N*N*DW-1:0]      b_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*ACC_W-1:0]   c_flat,
    output logic                   busy
);

    localparam int KW = $clog2(N);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N*N*DW-1:0] a_q, a_d;
    logic [N*N*DW-1:0] b_q, b_d;
    logic              acc_clr;
    logic              acc_en;

    logic [DW-1:0]     a_col [N];
    logic [DW-1:0]     b_row [N];

    // Next-state, operand capture and MAC control
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                acc_en = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, step counter and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Select column k of A and row k of B for this step's outer product
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_col[i] = a_q[(i * N + int'(k_q)) * DW +: DW];
            b_row[i] = b_q[(int'(k_q) * N + i) * DW +: DW];
        end
    end

    // One MAC cell per result element, driving c_flat straight from its register
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            matmul_mac #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_mac (
                .clk  (clk),
                .rst  (rst),
                .clr  (acc_clr),
                .en   (acc_en),
                .a_in (a_col[gi]),
                .b_in (b_row[gj]),
                .acc  (c_flat[(gi * N + gj) * ACC_W +: ACC_W])
            );
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matmul_engine.sv
// Directed self-checking bench for matmul_engine at N=4, DW=8, ACC_W=18.
// Build with MATMUL_SIGNED_EN defined to exercise the signed vectors.
module tb_matmul_engine;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 18;
    localparam int CWD = N * N * AW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N*N*DW-1:0]  a_flat = '0;
    logic [N*N*DW-1:0]  b_flat = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CWD-1:0]     c_flat;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    logic [7:0] ma [N][N];
    logic [7:0] mb [N][N];

    matmul_engine #(
        .N     (N),
        .DW    (DW),
        .ACC_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
        .busy      (busy)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [CWD-1:0] got, input logic [CWD-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference dot product for element (i,j) of ma x mb
    function automatic logic [AW-1:0] refElem(input int i, input int j);
        int acc = 0;
        for (int k = 0; k < N; k++) begin
`ifdef MATMUL_SIGNED_EN
            acc = acc + int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
`else
            acc = acc + int'(ma[i][k]) * int'(mb[k][j]);
`endif
        end
        return AW'(acc);
    endfunction

    function automatic logic [CWD-1:0] refFlat();
        logic [CWD-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i * N + j) * AW +: AW] = refElem(i, j);
        return r;
    endfunction

    function automatic logic [AW-1:0] cElem(input int i, input int j);
        return c_flat[(i * N + j) * AW +: AW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillMats(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = av;
                mb[i][j] = bv;
            end
    endtask

    // Present ma/mb and complete one input handshake
    task automatic applyStimulus(input string tag, input bit keep_valid);
        int waited = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_flat[(i * N + j) * DW +: DW] = ma[i][j];
                b_flat[(i * N + j) * DW +: DW] = mb[i][j];
            end
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) checkOutput({tag, "_hs_timeout"}, CWD'(0), CWD'(1));
        hs_cyc = cyc;
        tick();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Wait for out_valid and check handshake-to-valid latency
    task automatic waitResult(input string tag);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!out_valid) checkOutput({tag, "_result_timeout"}, CWD'(0), CWD'(1));
        else checkOutput({tag, "_latency"}, CWD'(cyc - hs_cyc), CWD'(N + 1));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_ovalid_after"}, CWD'(out_valid), CWD'(0));
        checkOutput({tag, "_iready_after"}, CWD'(in_ready), CWD'(1));
    endtask

    initial begin
        int saw_valid;
        int b2b_hs [3];

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", CWD'(in_ready), CWD'(1));
        checkOutput("rst_out_valid", CWD'(out_valid), CWD'(0));
        checkOutput("rst_busy", CWD'(busy), CWD'(0));
        checkOutput("rst_c_flat", c_flat, CWD'(0));

        // out_ready while idle is ignored
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        checkOutput("idle_oready_busy", CWD'(busy), CWD'(0));
        checkOutput("idle_oready_ovalid", CWD'(out_valid), CWD'(0));

        // Identity x (1..16): C equals B widened
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(i * N + j + 1);
            end
        applyStimulus("ident", 1'b0);
        checkOutput("ident_busy", CWD'(busy), CWD'(1));
        waitResult("ident");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("ident_c%0d%0d", i, j), CWD'(cElem(i, j)), CWD'(i * N + j + 1));
        consume("ident");

`ifdef MATMUL_SIGNED_EN
        // Most negative operands: (-128)^2 * 4 = 65536
        fillMats(8'h80, 8'h80);
        applyStimulus("neg", 1'b0);
        waitResult("neg");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("neg_c%0d%0d", i, j), CWD'(cElem(i, j)), CWD'(65536));
        consume("neg");
`else
        // All-ones operands: 255*255*4 = 260100 without wrap
        fillMats(8'hFF, 8'hFF);
        applyStimulus("max", 1'b0);
        waitResult("max");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("max_c%0d%0d", i, j), CWD'(cElem(i, j)), CWD'(18'h3F804));
        consume("max");
`endif

        // a[0][0]=0xFF, B identity: -1 sign-extended when signed, 255 otherwise
        fillMats(8'h00, 8'h00);
        ma[0][0] = 8'hFF;
        for (int i = 0; i < N; i++) mb[i][i] = 8'd1;
        applyStimulus("m1", 1'b0);
        waitResult("m1");
`ifdef MATMUL_SIGNED_EN
        checkOutput("m1_c00", CWD'(cElem(0, 0)), CWD'(18'h3FFFF));
`else
        checkOutput("m1_c00", CWD'(cElem(0, 0)), CWD'(18'h000FF));
`endif
        checkOutput("m1_rest", c_flat >> AW, CWD'(0));
        consume("m1");

        // Hold result for 10 cycles; operand changes and in_valid outside IDLE ignored
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 8'(3 * i + j + 2);
                mb[i][j] = 8'(7 * j - i + 40);
            end
        applyStimulus("hold", 1'b0);
        a_flat   = {N * N{8'h11}};
        b_flat   = {N * N{8'h22}};
        in_valid = 1'b1;
        waitResult("hold");
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("hold_c_%0d", c), c_flat, refFlat());
            checkOutput($sformatf("hold_ovalid_%0d", c), CWD'(out_valid), CWD'(1));
            checkOutput($sformatf("hold_iready_%0d", c), CWD'(in_ready), CWD'(0));
            tick();
        end
        in_valid = 1'b0;
        consume("hold");
        tick();
        checkOutput("hold_no_restart", CWD'(busy), CWD'(0));

        // Reset at COMPUTE step k=2 aborts the operation
        fillMats(8'h05, 8'h06);
        applyStimulus("abort", 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready", CWD'(in_ready), CWD'(1));
        checkOutput("abort_busy", CWD'(busy), CWD'(0));
        checkOutput("abort_c_flat", c_flat, CWD'(0));
        saw_valid = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) saw_valid++;
            tick();
        end
        checkOutput("abort_no_ovalid", CWD'(saw_valid), CWD'(0));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 8'(i + 2 * j + 1);
                mb[i][j] = 8'(4 * i + j + 9);
            end
        applyStimulus("after_abort", 1'b0);
        waitResult("after_abort");
        checkOutput("after_abort_c", c_flat, refFlat());
        consume("after_abort");

        // Back-to-back operations with out_ready tied high
        out_ready = 1'b1;
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = 8'(op * 37 + i * 11 + j * 5 + 1);
                    mb[i][j] = 8'(op * 19 + j * 13 + i * 3 + 2);
                end
            applyStimulus($sformatf("b2b%0d", op), 1'b1);
            b2b_hs[op] = hs_cyc;
            waitResult($sformatf("b2b%0d", op));
            checkOutput($sformatf("b2b%0d_c", op), c_flat, refFlat());
            if (op > 0)
                checkOutput($sformatf("b2b%0d_spacing", op), CWD'(b2b_hs[op] - b2b_hs[op-1]), CWD'(N + 2));
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_end_idle", CWD'(in_ready), CWD'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
